// File: rtl/keccak_byte_packer_pkg.sv
// Shared definitions for the keccak byte-to-word feeder: FSM states, widths and slot payload.
package keccak_byte_packer_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned BYTE_NUM_W = 2;

    typedef logic [1:0] state_t;

    localparam state_t ST_FILL  = 2'd0;
    localparam state_t ST_PAD0  = 2'd1;
    localparam state_t ST_LASTQ = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    typedef struct packed {
        logic [WORD_W-1:0]     data;
        logic                  is_last;
        logic [BYTE_NUM_W-1:0] byte_num;
    } slot_word_t;

    // Insert byte b at position pos of a big-endian word; byte 0 lands in [31:24].
    function automatic logic [WORD_W-1:0] place_byte(
        input logic [WORD_W-1:0]     acc,
        input logic [BYTE_NUM_W-1:0] pos,
        input logic [BYTE_W-1:0]     b
    );
        logic [WORD_W-1:0] res;
        case (pos)
            2'd0:    res = {b, 24'h0};
            2'd1:    res = {acc[31:24], b, 16'h0};
            2'd2:    res = {acc[31:16], b, 8'h0};
            default: res = {acc[31:8], b};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/keccak_word_slot.sv
// One-entry output register; a load in the same cycle as a fire keeps the slot valid.
module keccak_word_slot
    import keccak_byte_packer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       fire,
    input  slot_word_t load_word,
    output slot_word_t word,
    output logic       out_valid
);

    always_ff @(posedge clk) begin
        if (reset) begin
            word      <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            word      <= load_word;
            out_valid <= 1'b1;
        end else if (fire) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/keccak_byte_packer.sv
// Packs a valid/ready/last byte stream into 32-bit words for the keccak core,
// adding the zero-length trailing word when the message is a multiple of 4 bytes.
module keccak_byte_packer
    import keccak_byte_packer_pkg::*;
#(
    parameter int unsigned WCNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_valid,
    input  logic [BYTE_W-1:0]     s_data,
    input  logic                  s_last,
    output logic                  s_ready,
    input  logic                  buffer_full,
    output logic [WORD_W-1:0]     in,
    output logic                  in_ready,
    output logic                  is_last,
    output logic [BYTE_NUM_W-1:0] byte_num,
    output logic                  done,
    output logic [WCNT_W-1:0]     word_count
);

    state_t                state, state_next;
    logic [WORD_W-1:0]     asm_data, asm_data_next;
    logic [BYTE_NUM_W-1:0] asm_cnt, asm_cnt_next;
    logic                  out_valid;
    logic                  fire;
    logic                  slot_free;
    logic                  accept;
    logic                  load;
    slot_word_t            load_word;
    slot_word_t            slot_word;
    logic [WORD_W-1:0]     filled;

    assign fire      = out_valid & ~buffer_full;
    assign in_ready  = fire;
    assign slot_free = ~out_valid | fire;
    assign s_ready   = (state == ST_FILL) & slot_free;
    assign accept    = s_valid & s_ready;
    assign filled    = place_byte(asm_data, asm_cnt, s_data);

    assign in       = slot_word.data;
    assign is_last  = slot_word.is_last;
    assign byte_num = slot_word.byte_num;

    keccak_word_slot u_slot (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .fire      (fire),
        .load_word (load_word),
        .word      (slot_word),
        .out_valid (out_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_FILL;
            asm_data <= '0;
            asm_cnt  <= '0;
        end else begin
            state    <= state_next;
            asm_data <= asm_data_next;
            asm_cnt  <= asm_cnt_next;
        end
    end

    // Next state, assembler update and slot load request.
    always_comb begin
        state_next    = state;
        asm_data_next = asm_data;
        asm_cnt_next  = asm_cnt;
        load          = 1'b0;
        load_word     = '0;
        case (state)
            ST_FILL: begin
                if (accept) begin
                    if (s_last || asm_cnt == 2'd3) begin
                        load           = 1'b1;
                        load_word.data = filled;
                        asm_data_next  = '0;
                        asm_cnt_next   = '0;
                        if (s_last) begin
                            if (asm_cnt == 2'd3) begin
                                state_next = ST_PAD0;
                            end else begin
                                load_word.is_last  = 1'b1;
                                load_word.byte_num = asm_cnt + 2'd1;
                                state_next         = ST_LASTQ;
                            end
                        end
                    end else begin
                        asm_data_next = filled;
                        asm_cnt_next  = asm_cnt + 2'd1;
                    end
                end
            end
            ST_PAD0: begin
                if (slot_free) begin
                    load              = 1'b1;
                    load_word.is_last = 1'b1;
                    state_next        = ST_LASTQ;
                end
            end
            ST_LASTQ: begin
                if (fire) begin
                    state_next = ST_DONE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            done       <= 1'b0;
            word_count <= '0;
        end else begin
            if (state == ST_LASTQ && fire) begin
                done <= 1'b1;
            end
            if (fire && word_count != '1) begin
                word_count <= word_count + WCNT_W'(1);
            end
        end
    end

endmodule
